// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared types, board geometry, palette and fixed colours
//
// Purpose: tile code enum, board dimensions and the colour lookups used by
// tetris_board_render and tetris_board_store.
// Ports: none (package).
package tetris_pkg;

  typedef enum logic [2:0] {
    TILE_EMPTY = 3'd0,
    TILE_I     = 3'd1,
    TILE_O     = 3'd2,
    TILE_T     = 3'd3,
    TILE_S     = 3'd4,
    TILE_Z     = 3'd5,
    TILE_J     = 3'd6,
    TILE_L     = 3'd7
  } tile_t;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int TILE_SHIFT = 4;
  localparam int BORDER_W   = 4;

  localparam int TILE_COUNT = BOARD_COLS * BOARD_ROWS;
  localparam int BOARD_W_PX = BOARD_COLS << TILE_SHIFT;
  localparam int BOARD_H_PX = BOARD_ROWS << TILE_SHIFT;

  localparam logic [23:0] BORDER_RGB = 24'hC0C0C0;
  localparam logic [23:0] BG_RGB     = 24'h202020;

  function automatic logic [23:0] palette(tile_t t);
    logic [23:0] c;
    c = 24'h000000;
    case (t)
      TILE_I:  c = 24'h00FFFF;
      TILE_O:  c = 24'hFFFF00;
      TILE_T:  c = 24'hA000FF;
      TILE_S:  c = 24'h00FF00;
      TILE_Z:  c = 24'hFF0000;
      TILE_J:  c = 24'h0000FF;
      TILE_L:  c = 24'hFFA000;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tetris_board_render_if.sv
// rtl/tetris_board_render_if.sv - tile write / board clear bus from game logic
//
// Purpose: groups the tile write handshake and the clear request.
// Signals: wr_valid, wr_ready, wr_row[4:0], wr_col[3:0], wr_tile[2:0], clr_valid.
// Modports: master = game logic, slave = board store.
interface tetris_board_render_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_row;
  logic [3:0] wr_col;
  logic [2:0] wr_tile;
  logic       clr_valid;

  modport master (
    output wr_valid, wr_row, wr_col, wr_tile, clr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_tile, clr_valid,
    output wr_ready
  );
endinterface

// File: rtl/tetris_board_store.sv
// rtl/tetris_board_store.sv - 10x20 tile store with write, clear and frame commit
//
// Purpose: holds the playfield tiles; accepts writes/clears from the bus and
// exposes a combinational read port for the pixel pipeline.
// Ports: clk, reset_n (async, active-low), wr_bus (slave modport),
//        commit (frame-start pulse, 0 when single-buffered),
//        rd_row/rd_col (tile coordinates), rd_tile (tile code read).
// Macro: TETRIS_BOARD_DOUBLE_BUFFER_EN selects shadow + display stores.
module tetris_board_store
  import tetris_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  tetris_board_render_if.slave  wr_bus,
  input  logic                  commit,
  input  logic [4:0]            rd_row,
  input  logic [3:0]            rd_col,
  output tile_t                 rd_tile
);

  localparam logic [7:0] COLS8 = 8'(BOARD_COLS);

  tile_t      disp_mem [TILE_COUNT];
  logic       wr_fire;
  logic       wr_in_range;
  logic [7:0] wr_idx;
  logic       rd_in_range;
  logic [7:0] rd_idx;

  assign wr_bus.wr_ready = !wr_bus.clr_valid && !commit;
  assign wr_fire         = wr_bus.wr_valid && wr_bus.wr_ready;

  // Out-of-range writes still complete the handshake; they just never land.
  assign wr_in_range = (wr_bus.wr_row < 5'(BOARD_ROWS)) && (wr_bus.wr_col < 4'(BOARD_COLS));
  assign wr_idx      = {3'b000, wr_bus.wr_row} * COLS8 + {4'b0000, wr_bus.wr_col};

`ifdef TETRIS_BOARD_DOUBLE_BUFFER_EN
  tile_t shadow_mem [TILE_COUNT];

  // The commit copy reads the shadow before this edge's clear, so a clear
  // issued in the commit cycle only shows from the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TILE_COUNT; i++) begin
        shadow_mem[i] <= TILE_EMPTY;
        disp_mem[i]   <= TILE_EMPTY;
      end
    end else begin
      if (commit) begin
        disp_mem <= shadow_mem;
      end
      if (wr_bus.clr_valid) begin
        for (int i = 0; i < TILE_COUNT; i++) begin
          shadow_mem[i] <= TILE_EMPTY;
        end
      end else if (wr_fire && wr_in_range) begin
        shadow_mem[wr_idx] <= tile_t'(wr_bus.wr_tile);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TILE_COUNT; i++) begin
        disp_mem[i] <= TILE_EMPTY;
      end
    end else if (wr_bus.clr_valid) begin
      for (int i = 0; i < TILE_COUNT; i++) begin
        disp_mem[i] <= TILE_EMPTY;
      end
    end else if (wr_fire && wr_in_range) begin
      disp_mem[wr_idx] <= tile_t'(wr_bus.wr_tile);
    end
  end
`endif

  // Coordinates outside the board read as empty so the pipeline never
  // indexes past the array when the pixel is off the playfield.
  assign rd_in_range = (rd_row < 5'(BOARD_ROWS)) && (rd_col < 4'(BOARD_COLS));
  assign rd_idx      = {3'b000, rd_row} * COLS8 + {4'b0000, rd_col};
  assign rd_tile     = rd_in_range ? disp_mem[rd_idx] : TILE_EMPTY;

endmodule

// File: rtl/tetris_board_render.sv
// rtl/tetris_board_render.sv - two-stage pixel colour pipeline for the Tetris screen
//
// Purpose: maps VGA row/col to playfield, border or background colour using
// the live tile store; sync and blank are delayed to match the RGB.
// Ports: clk, reset_n (async, active-low), vga_row/vga_col/vga_blank/vga_hs/
//        vga_vs (timing generator), wr_bus (slave modport: tile writes, clear),
//        rgb_r/rgb_g/rgb_b, out_hs/out_vs/out_blank (2-cycle latency).
// Macro: TETRIS_BOARD_DOUBLE_BUFFER_EN enables frame-synchronous commit.
module tetris_board_render
  import tetris_pkg::*;
#(
  parameter int BOARD_X0 = 240,
  parameter int BOARD_Y0 = 80
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [9:0]            vga_row,
  input  logic [9:0]            vga_col,
  input  logic                  vga_blank,
  input  logic                  vga_hs,
  input  logic                  vga_vs,
  tetris_board_render_if.slave  wr_bus,
  output logic [7:0]            rgb_r,
  output logic [7:0]            rgb_g,
  output logic [7:0]            rgb_b,
  output logic                  out_hs,
  output logic                  out_vs,
  output logic                  out_blank
);

  localparam logic [9:0] X_LO  = 10'(BOARD_X0);
  localparam logic [9:0] X_HI  = 10'(BOARD_X0 + BOARD_W_PX);
  localparam logic [9:0] Y_LO  = 10'(BOARD_Y0);
  localparam logic [9:0] Y_HI  = 10'(BOARD_Y0 + BOARD_H_PX);
  localparam logic [9:0] BX_LO = 10'(BOARD_X0 - BORDER_W);
  localparam logic [9:0] BX_HI = 10'(BOARD_X0 + BOARD_W_PX + BORDER_W);
  localparam logic [9:0] BY_LO = 10'(BOARD_Y0 - BORDER_W);
  localparam logic [9:0] BY_HI = 10'(BOARD_Y0 + BOARD_H_PX + BORDER_W);

  logic       commit;
  logic       in_board_c, in_frame_c;
  logic [7:0] dx_c;
  logic [8:0] dy_c;

  logic       s1_in_board, s1_in_border, s1_grid;
  logic [4:0] s1_tile_row;
  logic [3:0] s1_tile_col;
  logic       s1_blank, s1_hs, s1_vs;

  tile_t       s1_tile;
  logic [23:0] s2_rgb_c;
  logic [23:0] s2_rgb;
  logic        s2_blank, s2_hs, s2_vs;

`ifdef TETRIS_BOARD_DOUBLE_BUFFER_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit <= 1'b0;
    end else begin
      commit <= (vga_row == 10'd0) && (vga_col == 10'd0);
    end
  end
`else
  assign commit = 1'b0;
`endif

  tetris_board_store u_store (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_bus  (wr_bus),
    .commit  (commit),
    .rd_row  (s1_tile_row),
    .rd_col  (s1_tile_col),
    .rd_tile (s1_tile)
  );

  // Region tests happen on the raw coordinates, so the offsets below are only
  // meaningful (and never wrap) when in_board_c is set. The playfield is at
  // most 160 px wide / 320 px tall, so 8 and 9 offset bits suffice.
  assign in_board_c = (vga_col >= X_LO) && (vga_col < X_HI) &&
                      (vga_row >= Y_LO) && (vga_row < Y_HI);
  assign in_frame_c = (vga_col >= BX_LO) && (vga_col < BX_HI) &&
                      (vga_row >= BY_LO) && (vga_row < BY_HI);
  assign dx_c = vga_col[7:0] - X_LO[7:0];
  assign dy_c = vga_row[8:0] - Y_LO[8:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_in_board  <= 1'b0;
      s1_in_border <= 1'b0;
      s1_grid      <= 1'b0;
      s1_tile_row  <= 5'd0;
      s1_tile_col  <= 4'd0;
      s1_blank     <= 1'b1;
      s1_hs        <= 1'b1;
      s1_vs        <= 1'b1;
    end else begin
      s1_in_board  <= in_board_c;
      s1_in_border <= in_frame_c && !in_board_c;
      s1_grid      <= (dx_c[3:0] == 4'd0) || (dy_c[3:0] == 4'd0);
      s1_tile_row  <= dy_c[8:4];
      s1_tile_col  <= dx_c[7:4];
      s1_blank     <= vga_blank;
      s1_hs        <= vga_hs;
      s1_vs        <= vga_vs;
    end
  end

  always_comb begin
    s2_rgb_c = BG_RGB;
    if (s1_blank) begin
      s2_rgb_c = 24'h000000;
    end else if (s1_in_board) begin
      if (s1_tile == TILE_EMPTY) begin
        s2_rgb_c = 24'h000000;
      end else if (s1_grid) begin
        // Grid line: halve every channel independently.
        s2_rgb_c = (palette(s1_tile) >> 1) & 24'h7F7F7F;
      end else begin
        s2_rgb_c = palette(s1_tile);
      end
    end else if (s1_in_border) begin
      s2_rgb_c = BORDER_RGB;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_rgb   <= 24'h000000;
      s2_blank <= 1'b1;
      s2_hs    <= 1'b1;
      s2_vs    <= 1'b1;
    end else begin
      s2_rgb   <= s2_rgb_c;
      s2_blank <= s1_blank;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
    end
  end

  assign rgb_r     = s2_rgb[23:16];
  assign rgb_g     = s2_rgb[15:8];
  assign rgb_b     = s2_rgb[7:0];
  assign out_hs    = s2_hs;
  assign out_vs    = s2_vs;
  assign out_blank = s2_blank;

endmodule

// File: tb/tb_tetris_board_render.sv
// tb/tb_tetris_board_render.sv - self-checking bench for tetris_board_render
module tb_tetris_board_render;

  localparam int X0 = 240;
  localparam int Y0 = 80;

  typedef struct {
    int row;
    int col;
    bit blank;
    bit hs;
    bit vs;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] vga_row, vga_col;
  logic       vga_blank, vga_hs, vga_vs;
  logic [7:0] rgb_r, rgb_g, rgb_b;
  logic       out_hs, out_vs, out_blank;

  int vectors = 0;
  int miscompares = 0;

  tetris_board_render_if wr_if ();

  tetris_board_render #(.BOARD_X0(X0), .BOARD_Y0(Y0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .vga_row   (vga_row),
    .vga_col   (vga_col),
    .vga_blank (vga_blank),
    .vga_hs    (vga_hs),
    .vga_vs    (vga_vs),
    .wr_bus    (wr_if),
    .rgb_r     (rgb_r),
    .rgb_g     (rgb_g),
    .rgb_b     (rgb_b),
    .out_hs    (out_hs),
    .out_vs    (out_vs),
    .out_blank (out_blank)
  );

  always #10 clk = ~clk;

  int pal_r [8] = '{0, 0, 255, 160, 0, 255, 0, 255};
  int pal_g [8] = '{0, 255, 255, 0, 255, 0, 0, 160};
  int pal_b [8] = '{0, 255, 0, 255, 0, 0, 255, 0};

  int          disp_m [20][10];
  int          shad_m [20][10];
  pix_t        h1 = '{0, 0, 1'b1, 1'b1, 1'b1};
  logic [26:0] exp_out = {3'b111, 24'h000000};
  bit          commit_m = 1'b0;
  bit          acc;
  int          wr_r, wr_c;

  task automatic check_vec(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Colour of one pixel straight from the screen rules, using the model board.
  function automatic logic [26:0] ref_pix(pix_t p);
    int r, g, b, ox, oy, t;
    r = 32; g = 32; b = 32;
    if (p.blank) begin
      r = 0; g = 0; b = 0;
    end else if (p.col >= X0 && p.col < X0 + 160 && p.row >= Y0 && p.row < Y0 + 320) begin
      ox = p.col - X0;
      oy = p.row - Y0;
      t  = disp_m[oy / 16][ox / 16];
      r = pal_r[t]; g = pal_g[t]; b = pal_b[t];
      if (ox % 16 == 0 || oy % 16 == 0) begin
        r = r / 2; g = g / 2; b = b / 2;
      end
    end else if (p.col >= X0 - 4 && p.col < X0 + 164 && p.row >= Y0 - 4 && p.row < Y0 + 324) begin
      r = 192; g = 192; b = 192;
    end
    return {p.hs, p.vs, p.blank, 8'(r), 8'(g), 8'(b)};
  endfunction

  // Scoreboard: the pixel captured last edge is coloured from the board as it
  // stood before this edge; then this edge's write/clear/commit is applied.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      foreach (disp_m[i, j]) begin
        disp_m[i][j] = 0;
        shad_m[i][j] = 0;
      end
      h1       = '{0, 0, 1'b1, 1'b1, 1'b1};
      exp_out  = {3'b111, 24'h000000};
      commit_m = 1'b0;
    end else begin
      exp_out = ref_pix(h1);
      acc  = wr_if.wr_valid && !wr_if.clr_valid && !commit_m;
      wr_r = int'(wr_if.wr_row);
      wr_c = int'(wr_if.wr_col);
`ifdef TETRIS_BOARD_DOUBLE_BUFFER_EN
      if (commit_m) disp_m = shad_m;
      if (wr_if.clr_valid) begin
        foreach (shad_m[i, j]) shad_m[i][j] = 0;
      end else if (acc && wr_r < 20 && wr_c < 10) begin
        shad_m[wr_r][wr_c] = int'(wr_if.wr_tile);
      end
      commit_m = (vga_row == 10'd0) && (vga_col == 10'd0);
`else
      if (wr_if.clr_valid) begin
        foreach (disp_m[i, j]) disp_m[i][j] = 0;
      end else if (acc && wr_r < 20 && wr_c < 10) begin
        disp_m[wr_r][wr_c] = int'(wr_if.wr_tile);
      end
`endif
      h1 = '{int'(vga_row), int'(vga_col), vga_blank, vga_hs, vga_vs};
    end
  end

  always @(negedge clk) begin
    check_vec("pixel", {5'd0, out_hs, out_vs, out_blank, rgb_r, rgb_g, rgb_b}, {5'd0, exp_out});
  end

  task automatic tick();
    #1 check_vec("wr_ready", {31'd0, wr_if.wr_ready}, {31'd0, !wr_if.clr_valid && !commit_m});
    @(negedge clk);
  endtask

  task automatic set_pix(int r, int c, bit b);
    vga_row   = 10'(r);
    vga_col   = 10'(c);
    vga_blank = b;
  endtask

  task automatic write_tile(int r, int c, int t);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_row   = 5'(r);
    wr_if.wr_col   = 4'(c);
    wr_if.wr_tile  = 3'(t);
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic pass_origin();
    set_pix(0, 0, 1'b0);
    tick();
  endtask

  task automatic check_rgb(string tag, logic [23:0] exp);
    check_vec(tag, {8'd0, rgb_r, rgb_g, rgb_b}, {8'd0, exp});
  endtask

  int hs_low, hs_first;

  initial begin
    reset_n         = 1'b0;
    vga_hs          = 1'b1;
    vga_vs          = 1'b1;
    wr_if.wr_valid  = 1'b0;
    wr_if.wr_row    = 5'd0;
    wr_if.wr_col    = 4'd0;
    wr_if.wr_tile   = 3'd0;
    wr_if.clr_valid = 1'b0;
    set_pix(300, 600, 1'b1);
    repeat (3) tick();
    check_rgb("rst_rgb", 24'h000000);
    check_vec("rst_sync", {29'd0, out_hs, out_vs, out_blank}, 32'd7);
    #2 reset_n = 1'b1;
    #1 check_vec("rst_ready", {31'd0, wr_if.wr_ready}, 32'd1);

    set_pix(100, 300, 1'b0); tick(); tick();
    check_rgb("empty_board", 24'h000000);
    check_vec("blank_low", {31'd0, out_blank}, 32'd0);
    set_pix(77, 300, 1'b0); tick(); tick();
    check_rgb("border", 24'hC0C0C0);
    set_pix(60, 100, 1'b0); tick(); tick();
    check_rgb("background", 24'h202020);

    write_tile(0, 0, 6);
    pass_origin();
    set_pix(81, 241, 1'b0); tick(); tick();
    check_rgb("tile_j", 24'h0000FF);
    set_pix(80, 245, 1'b0); tick(); tick();
    check_rgb("grid_j", 24'h00007F);

    write_tile(25, 0, 3);
    pass_origin();
    set_pix(81, 241, 1'b0); tick(); tick();
    check_rgb("oob_write", 24'h0000FF);

    wr_if.clr_valid = 1'b1;
    wr_if.wr_valid  = 1'b1;
    wr_if.wr_row    = 5'd1;
    wr_if.wr_col    = 4'd1;
    wr_if.wr_tile   = 3'd2;
    #1 check_vec("clr_ready", {31'd0, wr_if.wr_ready}, 32'd0);
    tick();
    wr_if.clr_valid = 1'b0;
    wr_if.wr_valid  = 1'b0;
    pass_origin();
    set_pix(81, 241, 1'b0); tick(); tick();
    check_rgb("cleared", 24'h000000);
    set_pix(97, 257, 1'b0); tick(); tick();
    check_rgb("clr_no_write", 24'h000000);

    write_tile(5, 5, 1);
    set_pix(163, 323, 1'b0); tick(); tick();
`ifdef TETRIS_BOARD_DOUBLE_BUFFER_EN
    check_rgb("pre_commit", 24'h000000);
    pass_origin();
    check_vec("commit_ready", {31'd0, wr_if.wr_ready}, 32'd0);
`else
    check_rgb("live_write", 24'h00FFFF);
    pass_origin();
    check_vec("commit_ready", {31'd0, wr_if.wr_ready}, 32'd1);
`endif
    set_pix(163, 323, 1'b0); tick(); tick();
    check_rgb("tile_i", 24'h00FFFF);

    set_pix(200, 300, 1'b0);
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        write_tile(r, c, 1 + (r + c) % 7);
    pass_origin();
    hs_low = 0;
    hs_first = -1;
    for (int k = 0; k < 102; k++) begin
      vga_hs = (k < 96) ? 1'b0 : 1'b1;
      set_pix(80 + (k * 3) % 320, 240 + (k * 7) % 160, 1'b1);
      tick();
      if (!out_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
    end
    check_vec("hs_len", hs_low, 96);
    check_vec("hs_delay", hs_first, 1);
    check_rgb("blank_full", 24'h000000);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 reset_n = 1'b0;
        tick(); tick();
        #2 reset_n = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) begin
        set_pix(0, 0, 1'b0);
      end else if ($urandom_range(0, 3) == 0) begin
        set_pix($urandom_range(0, 524), $urandom_range(0, 799), $urandom_range(0, 7) == 0);
      end else begin
        set_pix($urandom_range(70, 410), $urandom_range(230, 410), $urandom_range(0, 7) == 0);
      end
      vga_hs          = $urandom_range(0, 1);
      vga_vs          = $urandom_range(0, 1);
      wr_if.wr_valid  = ($urandom_range(0, 2) == 0);
      wr_if.wr_row    = 5'($urandom_range(0, 22));
      wr_if.wr_col    = 4'($urandom_range(0, 11));
      wr_if.wr_tile   = 3'($urandom_range(0, 7));
      wr_if.clr_valid = ($urandom_range(0, 49) == 0);
      tick();
    end
    wr_if.wr_valid  = 1'b0;
    wr_if.clr_valid = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
